// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset/step constants and PC-action encoding for the core.
package cpu_pkg;
    localparam int WIDTH = 16;
    localparam int IMM_W = 12;
    localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;
    localparam logic [WIDTH-1:0] PC_STEP = 16'd2;
    typedef enum logic [1:0] {PC_HOLD, PC_SEQ, PC_REL, PC_RA} pc_act_e;
    function automatic logic [WIDTH-1:0] sext(input logic [IMM_W-1:0] v);
        return {{(WIDTH-IMM_W){v[IMM_W-1]}}, v};
    endfunction
endpackage

// File: rtl/ra_stack.sv
// ra_stack: LIFO of saved return addresses; push when full and pop when empty are ignored.
module ra_stack #(
    parameter int W = 16,
    parameter int DEPTH = 8,
    localparam int DW = $clog2(DEPTH + 1),
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wi, ti;
    assign full = depth == DW'(DEPTH);
    assign empty = depth == '0;
    assign wi = AW'(depth);
    assign ti = AW'(depth - 1'b1);
    assign dout = mem[ti];
    always_ff @(posedge clk or negedge Reset)
        if (!Reset) depth <= '0;
        else if (clr) depth <= '0;
        else if (push && !full) depth <= depth + 1'b1;
        else if (pop && !empty) depth <= depth - 1'b1;
    // contents need no reset: depth alone decides what is valid
    always_ff @(posedge clk)
        if (push && !full && !clr) mem[wi] <= din;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC/RA registers with priority next-PC mux, branch compare and sticky stack/compare flags.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             writePC,
    input  logic             PCsrc,
    input  logic             ImRPC,
    input  logic             writeRA,
    input  logic             backup,
    input  logic             restore,
    input  logic             cmpeq,
    input  logic             cmpne,
    input  logic             resetSig,
    input  logic [IMM_W-1:0] imm,
    input  logic [WIDTH-1:0] cmp_a,
    input  logic [WIDTH-1:0] cmp_b,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] ra,
    output logic [DW-1:0]    stack_depth,
    output logic             br_taken,
    output logic             stk_ovf,
    output logic             stk_unf,
    output logic             cmp_err
);
    pc_act_e act;
    logic cond, taken, push, pop, full, empty;
    logic [WIDTH-1:0] top, pc_nxt;
    always_comb begin
        cond = cmpeq ? cmp_a == cmp_b : cmp_a != cmp_b;
        taken = 1'b0;
        act = PC_HOLD;
        if (writePC && PCsrc) act = PC_RA;
        else if (cmpeq || cmpne) begin
            taken = (cmpeq ^ cmpne) && cond;
            act = taken ? PC_REL : PC_HOLD;
        end
        else if (writePC) act = ImRPC ? PC_REL : PC_SEQ;
        pc_nxt = act == PC_RA  ? ra :
                 act == PC_REL ? pc + sext(imm) :
                 act == PC_SEQ ? pc + PC_STEP : pc;
    end
    // simultaneous backup and restore cancel out entirely
    assign push = backup && !restore;
    assign pop = restore && !backup && writeRA && PCsrc;
    ra_stack #(.W(WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
        .clk(clk),
        .Reset(Reset),
        .clr(resetSig),
        .push(push),
        .pop(pop),
        .din(ra),
        .dout(top),
        .depth(stack_depth),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk or negedge Reset)
        if (!Reset) begin
            pc <= RESET_PC;
            ra <= '0;
            br_taken <= 1'b0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
            cmp_err <= 1'b0;
        end
        else if (resetSig) begin
            pc <= RESET_PC;
            ra <= '0;
            br_taken <= 1'b0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
            cmp_err <= 1'b0;
        end
        else begin
            pc <= pc_nxt;
            if (pop) ra <= empty ? '0 : top;
            else if (writeRA && !PCsrc && !(backup && restore)) ra <= pc;
            br_taken <= taken;
            stk_ovf <= stk_ovf | (push & full);
            stk_unf <= stk_unf | (pop & empty);
            cmp_err <= cmp_err | (cmpeq & cmpne);
        end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plus random stimulus against a queue-based behavioural model of pc_unit.
module tb_pc_unit;
    logic clk = 1'b0;
    logic Reset;
    logic writePC, PCsrc, ImRPC, writeRA, backup, restore, cmpeq, cmpne, resetSig;
    logic [11:0] imm;
    logic [15:0] cmp_a, cmp_b;
    logic [15:0] pc, ra;
    logic [3:0] stack_depth;
    logic br_taken, stk_ovf, stk_unf, cmp_err;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    int m_pc = 0, m_ra = 0;
    bit m_br = 0, m_ovf = 0, m_unf = 0, m_err = 0;
    int stk[$];

    pc_unit dut (
        .clk(clk), .Reset(Reset), .writePC(writePC), .PCsrc(PCsrc), .ImRPC(ImRPC),
        .writeRA(writeRA), .backup(backup), .restore(restore), .cmpeq(cmpeq), .cmpne(cmpne),
        .resetSig(resetSig), .imm(imm), .cmp_a(cmp_a), .cmp_b(cmp_b), .pc(pc), .ra(ra),
        .stack_depth(stack_depth), .br_taken(br_taken), .stk_ovf(stk_ovf), .stk_unf(stk_unf),
        .cmp_err(cmp_err)
    );

    always #5 clk = ~clk;

    function automatic int sx(logic [11:0] v);
        return v[11] ? int'(v) - 4096 : int'(v);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ra = 0; m_br = 0; m_ovf = 0; m_unf = 0; m_err = 0;
        stk.delete();
    endtask

    // reference: each edge computed from the rules using the pre-edge model state
    always @(posedge clk or negedge Reset) begin
        if (!Reset || resetSig) model_reset();
        else begin
            int npc, nra;
            bit nbr;
            npc = m_pc; nra = m_ra; nbr = 0;
            if (writePC && PCsrc) npc = m_ra;
            else if (cmpeq && cmpne) npc = m_pc;
            else if (cmpeq || cmpne) begin
                if ((cmpeq && cmp_a == cmp_b) || (cmpne && cmp_a != cmp_b)) begin
                    npc = (m_pc + sx(imm)) & 16'hFFFF;
                    nbr = 1;
                end
            end
            else if (writePC) npc = (m_pc + (ImRPC ? sx(imm) : 2)) & 16'hFFFF;
            if (cmpeq && cmpne) m_err = 1;
            if (!(backup && restore)) begin
                if (backup) begin
                    if (stk.size() < 8) stk.push_back(m_ra);
                    else m_ovf = 1;
                end
                if (writeRA && PCsrc && restore) begin
                    if (stk.size() > 0) nra = stk.pop_back();
                    else begin
                        nra = 0;
                        m_unf = 1;
                    end
                end
                else if (writeRA && !PCsrc) nra = m_pc;
            end
            m_pc = npc; m_ra = nra; m_br = nbr;
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("pc", int'(pc), m_pc);
        chk("ra", int'(ra), m_ra);
        chk("depth", int'(stack_depth), stk.size());
        chk("br_taken", int'(br_taken), int'(m_br));
        chk("stk_ovf", int'(stk_ovf), int'(m_ovf));
        chk("stk_unf", int'(stk_unf), int'(m_unf));
        chk("cmp_err", int'(cmp_err), int'(m_err));
    end

    task automatic clr_in();
        writePC = 0; PCsrc = 0; ImRPC = 0; writeRA = 0; backup = 0; restore = 0;
        cmpeq = 0; cmpne = 0; resetSig = 0; imm = '0; cmp_a = '0; cmp_b = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cal(logic [11:0] off);
        clr_in(); writePC = 1; ImRPC = 1; writeRA = 1; backup = 1; imm = off;
    endtask

    task automatic ret();
        clr_in(); writePC = 1; PCsrc = 1; writeRA = 1; restore = 1;
    endtask

    initial begin
        Reset = 0;
        clr_in();
        repeat (2) @(negedge clk);
        chk("rst_pc", int'(pc), 0);
        chk("rst_ra", int'(ra), 0);
        chk("rst_depth", int'(stack_depth), 0);
        chk("rst_flags", int'({br_taken, stk_ovf, stk_unf, cmp_err}), 0);
        Reset = 1;
        chk_en = 1;
        writePC = 1;
        step(); chk("seq1", int'(pc), 2);
        step(); chk("seq2", int'(pc), 4);
        step(); chk("seq3", int'(pc), 6);
        repeat (5) step();
        chk("seq_10", int'(pc), 16'h0010);
        cal(12'h020); step();
        chk("cal_pc", int'(pc), 16'h0030);
        chk("cal_ra", int'(ra), 16'h0010);
        chk("cal_depth", int'(stack_depth), 1);
        ret(); step();
        chk("ret_pc", int'(pc), 16'h0010);
        chk("ret_ra", int'(ra), 0);
        chk("ret_depth", int'(stack_depth), 0);
        for (int i = 0; i < 9; i++) begin
            cal(12'h010); step();
        end
        chk("nest_depth", int'(stack_depth), 8);
        chk("nest_ovf", int'(stk_ovf), 1);
        chk("nest_ra", int'(ra), 16'h0090);
        for (int i = 0; i < 9; i++) begin
            ret(); step();
            if (i == 0) begin
                chk("unwind1_ra", int'(ra), 16'h0070);
                chk("unwind1_pc", int'(pc), 16'h0090);
            end
            if (i == 7) chk("unwind8_unf", int'(stk_unf), 0);
        end
        chk("unwind_unf", int'(stk_unf), 1);
        chk("unwind_ra", int'(ra), 0);
        chk("unwind_depth", int'(stack_depth), 0);
        clr_in(); resetSig = 1; step();
        chk("soft_flags", int'({stk_ovf, stk_unf}), 0);
        clr_in(); writePC = 1; ImRPC = 1; imm = 12'h040; step();
        chk("bop_pc", int'(pc), 16'h0040);
        clr_in(); cmpeq = 1; cmp_a = 5; cmp_b = 5; imm = 12'hFF8; step();
        chk("beq_pc", int'(pc), 16'h0038);
        chk("beq_br", int'(br_taken), 1);
        clr_in(); cmpne = 1; cmp_a = 5; cmp_b = 5; imm = 12'hFF8; step();
        chk("bne_pc", int'(pc), 16'h0038);
        chk("bne_br", int'(br_taken), 0);
        clr_in(); cmpeq = 1; cmpne = 1; cmp_a = 5; cmp_b = 5; imm = 12'hFF8; step();
        chk("both_pc", int'(pc), 16'h0038);
        chk("both_err", int'(cmp_err), 1);
        clr_in(); step();
        chk("err_held", int'(cmp_err), 1);
        clr_in(); resetSig = 1; step();
        chk("soft_pc", int'(pc), 0);
        chk("soft_err", int'(cmp_err), 0);
        clr_in(); writePC = 1; repeat (3) step();
        cal(12'h020); step();
        chk("pre_ra", int'(ra), 6);
        chk("pre_depth", int'(stack_depth), 1);
        cal(12'h020);
        #2 Reset = 0;
        #1;
        chk("async_pc", int'(pc), 0);
        chk("async_ra", int'(ra), 0);
        chk("async_depth", int'(stack_depth), 0);
        step();
        chk("async_nopush", int'(stack_depth), 0);
        Reset = 1;
        for (int n = 0; n < 3000; n++) begin
            int k;
            clr_in();
            k = $urandom_range(0, 15);
            if (k < 4) cal(12'($urandom));
            else if (k < 8) ret();
            else if (k < 10) writePC = 1;
            else if (k < 12) begin
                if ($urandom_range(0, 7) == 0) begin
                    cmpeq = 1; cmpne = 1;
                end
                else if ($urandom_range(0, 1) == 1) cmpeq = 1;
                else cmpne = 1;
                imm = 12'($urandom);
            end
            else if (k == 15 && $urandom_range(0, 7) == 0) resetSig = 1;
            else begin
                {writePC, PCsrc, ImRPC, writeRA, backup, restore} = 6'($urandom);
                cmpeq = $urandom_range(0, 9) == 0;
                cmpne = $urandom_range(0, 9) == 0;
                if (cmpeq || cmpne) writePC = 0;
                imm = 12'($urandom);
            end
            cmp_a = 16'($urandom_range(0, 3));
            cmp_b = 16'($urandom_range(0, 3));
            step();
        end
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
